sensor_monitor: RTL and testbench



---
 rtl/sensor_pkg.sv | 14 +
 rtl/sensor_sync2.sv | 24 ++
 rtl/sensor_monitor.sv | 117 +++++++++++
 tb/tb_sensor_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types and constants for the delay-line sensor readout
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } sense_state_t;

  localparam int SETTLE_CYC   = 2;
  localparam int WIN_LOG2_DEF = 8;

endpackage

// File: rtl/sensor_sync2.sv
// rtl/sensor_sync2.sv - two-flop synchronizer for a single sensor tap
module sensor_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sensor_monitor.sv
// rtl/sensor_monitor.sv - counts sampled-high sensor cycles per window and flags out-of-band results
module sensor_monitor
  import sensor_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sense_in,
  input  logic             start,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             clr_alarm,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  sense_state_t        state_q, state_d;
  logic [1:0]          settle_q, settle_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                alarm_q, alarm_d;
  logic [CNT_W-1:0]    acc_sum;
  logic                s;
  logic                win_last;
  logic                launch;
  logic                enter_done;

  sensor_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sense_in),
    .q_o   (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign win_last = (win_q == {WIN_LOG2{1'b1}});

  // A start seen in DONE chains straight into the next window, giving an N+3 cycle period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settle_q == 2'(SETTLE_CYC - 1)) state_d = MEASURE;
      MEASURE: if (win_last) state_d = DONE;
      DONE:    state_d = start ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign acc_sum    = acc_q + CNT_W'(s);
  assign launch     = (state_d == SETTLE) && (state_q != SETTLE);
  assign enter_done = (state_q == MEASURE) && win_last;

  always_comb begin
    settle_d = settle_q;
    win_d    = win_q;
    acc_d    = acc_q;
    count_d  = count_q;
    alarm_d  = alarm_q;
    if (launch) begin
      settle_d = 2'd0;
      win_d    = '0;
      acc_d    = '0;
    end else if (state_q == SETTLE) begin
      settle_d = settle_q + 2'd1;
    end else if (state_q == MEASURE) begin
      acc_d = acc_sum;
      win_d = win_q + 1'b1;
    end
    if (enter_done) begin
      count_d = acc_sum;
    end
    // Set beats a coincident clear so an out-of-band result is never lost.
    if (enter_done && ((acc_sum < thr_lo) || (acc_sum > thr_hi))) begin
      alarm_d = 1'b1;
    end else if (clr_alarm) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
      win_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      alarm_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      alarm_q  <= alarm_d;
    end
  end

  assign count = count_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// tb/tb_sensor_monitor.sv - scoreboard bench for sensor_monitor with a 16-cycle window
module tb_sensor_monitor;

  localparam int WL = 4;
  localparam int N  = 1 << WL;
  localparam int CW = WL + 1;

  logic          clk;
  logic          rst_n;
  logic          sense_in;
  logic          start;
  logic [CW-1:0] thr_lo;
  logic [CW-1:0] thr_hi;
  logic          clr_alarm;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          alarm;

  int            n_checks;
  int            n_errs;
  int            cyc;
  int            done_cnt;
  int            last_done_cyc;
  int            prev_done_cyc;
  logic          alarm_model;
  logic [CW:0]   sb[$];

  sensor_monitor #(.WIN_LOG2(WL), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sense_in  (sense_in),
    .start     (start),
    .thr_lo    (thr_lo),
    .thr_hi    (thr_hi),
    .clr_alarm (clr_alarm),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_done", 32'(done), 32'd0);
      end else begin
        logic [CW:0] e;
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e[CW-1:0]));
        chk("alarm", 32'(alarm), 32'(e[CW]));
      end
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
  end

  // mode: 0 high, 1 low, 2 toggle, 3 random
  task automatic run_meas(input int mode, input logic [CW-1:0] lo, input logic [CW-1:0] hi,
                          input bit clr_at_entry);
    bit pat[N+8];
    int exp_cnt;
    int lat;
    exp_cnt = 0;
    lat     = -1;
    for (int j = 0; j < N + 8; j++) begin
      case (mode)
        0:       pat[j] = 1'b1;
        1:       pat[j] = 1'b0;
        2:       pat[j] = j[0];
        default: pat[j] = 1'($urandom_range(0, 1));
      endcase
    end
    for (int j = 0; j < N; j++) exp_cnt += int'(pat[j]);
    if (exp_cnt < int'(lo) || exp_cnt > int'(hi)) alarm_model = 1'b1;
    sb.push_back({alarm_model, CW'(exp_cnt)});
    @(negedge clk);
    thr_lo = lo;
    thr_hi = hi;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    sense_in = pat[0];
    for (int j = 1; j < N + 7; j++) begin
      @(posedge clk);
      #1;
      sense_in  = pat[j];
      clr_alarm = clr_at_entry && (j == N + 1);
      if (done === 1'b1 && lat < 0) lat = j;
    end
    chk("latency", 32'(lat), 32'(N + 2));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_alarm = 1'b1;
    @(negedge clk);
    clr_alarm   = 1'b0;
    alarm_model = 1'b0;
    chk("alarm_clr", 32'(alarm), 32'd0);
  endtask

  initial begin
    int d0;
    int waited;
    n_checks      = 0;
    n_errs        = 0;
    cyc           = 0;
    done_cnt      = 0;
    last_done_cyc = 0;
    prev_done_cyc = 0;
    alarm_model   = 1'b0;
    rst_n         = 1'b0;
    sense_in      = 1'b0;
    start         = 1'b0;
    thr_lo        = '0;
    thr_hi        = '1;
    clr_alarm     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_meas(0, 5'd0, 5'd31, 1'b0);
    run_meas(1, 5'd4, 5'd31, 1'b0);
    pulse_clr();
    run_meas(2, 5'd6, 5'd10, 1'b0);
    run_meas(3, 5'd0, 5'd31, 1'b0);
    run_meas(3, 5'd7, 5'd9, 1'b0);
    pulse_clr();
    run_meas(1, 5'd4, 5'd31, 1'b1);

    // start held through three back-to-back windows
    @(negedge clk);
    sense_in = 1'b1;
    thr_lo   = 5'd0;
    thr_hi   = 5'd31;
    for (int k = 0; k < 3; k++) sb.push_back({alarm_model, CW'(N)});
    d0    = done_cnt;
    start = 1'b1;
    repeat (2 * (N + 3) + 1) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (N + 8) @(posedge clk);
    #1;
    chk("busy_dones", 32'(done_cnt - d0), 32'd3);
    chk("busy_period", 32'(last_done_cyc - prev_done_cyc), 32'(N + 3));
    chk("busy_idle", 32'(busy), 32'd0);

    // reset during MEASURE cycle 7
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count), 32'(N));
    chk("pre_rst_alarm", 32'(alarm), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_alarm", 32'(alarm), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    alarm_model = 1'b0;
    run_meas(0, 5'd0, 5'd31, 1'b0);

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
